// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared MU0 constants and memory arbiter types
package mu0_pkg;

  localparam int MU0_AW = 12;
  localparam int MU0_DW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic GRANT_CPU  = 1'b0;
  localparam logic GRANT_HOST = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - load/decrement down-counter with zero flag for memory wait states
module mem_wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mu0_mem_arbiter.sv
// rtl/mu0_mem_arbiter.sv - shares the MU0 memory between the CPU and a host loader/debug port
module mu0_mem_arbiter
  import mu0_pkg::*;
#(
  parameter int AW          = MU0_AW,
  parameter int DW          = MU0_DW,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_memrq,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait,
  input  logic          host_halt,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Counter needs at least one bit even when no wait states are configured.
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  arb_state_t state;
  logic       grant;
  logic       last_grant;
  logic       cpu_done;
  logic       cpu_elig;
  logic       host_elig;
  logic       pick_host;
  logic       wait_zero;

  // A requester is ignored during its own completion pulse.
  assign cpu_elig  = cpu_memrq & ~host_halt & ~cpu_done;
  assign host_elig = host_req & ~host_ack;
  assign pick_host = host_elig & (~cpu_elig | (last_grant == GRANT_CPU));
  assign cpu_wait  = cpu_memrq & ~cpu_done;

  mem_wait_counter #(
    .WIDTH(CW)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (state == ISSUE),
    .load_value(WS_LOAD),
    .dec       (state == WAIT),
    .zero      (wait_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GRANT_CPU;
      last_grant <= GRANT_HOST;
      cpu_done   <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_done <= 1'b0;
      host_ack <= 1'b0;
      mem_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_elig || host_elig) begin
            // Access fields are latched so a dropped request still completes cleanly.
            grant     <= pick_host ? GRANT_HOST : GRANT_CPU;
            mem_en    <= 1'b1;
            mem_we    <= pick_host ? host_we : ~cpu_rnw;
            mem_addr  <= pick_host ? host_addr : cpu_addr;
            mem_wdata <= pick_host ? host_wdata : cpu_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= (WAIT_STATES > 0) ? WAIT : DONE;
        end
        WAIT: begin
          if (wait_zero) begin
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= grant;
          if (grant == GRANT_CPU) begin
            cpu_done <= 1'b1;
            if (!mem_we) begin
              cpu_rdata <= mem_rdata;
            end
          end else begin
            host_ack <= 1'b1;
            if (!mem_we) begin
              host_rdata <= mem_rdata;
            end
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// tb/tb_mu0_mem_arbiter.sv - directed self-checking bench for mu0_mem_arbiter at W=1, W=0 and W=7
module tb_mu0_mem_arbiter;

  logic clk;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: WAIT_STATES=1
  logic        a_rst, a_cpu_memrq, a_cpu_rnw, a_cpu_wait, a_host_halt, a_host_req, a_host_we, a_host_ack;
  logic        a_mem_en, a_mem_we;
  logic [11:0] a_cpu_addr, a_host_addr, a_mem_addr;
  logic [15:0] a_cpu_wdata, a_cpu_rdata, a_host_wdata, a_host_rdata, a_mem_wdata, a_mem_rdata;
  logic [15:0] mem_a [0:4095];

  // Instance b: WAIT_STATES=0, host only
  logic        bc_rst, b_host_req, b_host_we, b_host_ack, b_cpu_wait, b_mem_en, b_mem_we;
  logic [11:0] b_host_addr, b_mem_addr;
  logic [15:0] b_host_wdata, b_host_rdata, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic [15:0] mem_b [0:4095];

  // Instance c: WAIT_STATES=7, CPU only
  logic        c_cpu_memrq, c_cpu_rnw, c_cpu_wait, c_host_ack, c_mem_en, c_mem_we;
  logic [11:0] c_cpu_addr, c_mem_addr;
  logic [15:0] c_cpu_rdata, c_host_rdata, c_mem_wdata, c_mem_rdata;
  logic [15:0] mem_c [0:4095];

  mu0_mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(1)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .cpu_memrq(a_cpu_memrq), .cpu_rnw(a_cpu_rnw), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_wait(a_cpu_wait),
    .host_halt(a_host_halt), .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr),
    .host_wdata(a_host_wdata), .host_ack(a_host_ack), .host_rdata(a_host_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );

  mu0_mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst(bc_rst),
    .cpu_memrq(1'b0), .cpu_rnw(1'b1), .cpu_addr(12'h000), .cpu_wdata(16'h0000),
    .cpu_rdata(b_cpu_rdata), .cpu_wait(b_cpu_wait),
    .host_halt(1'b0), .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr),
    .host_wdata(b_host_wdata), .host_ack(b_host_ack), .host_rdata(b_host_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );

  mu0_mem_arbiter #(.AW(12), .DW(16), .WAIT_STATES(7)) u_dut_c (
    .clk(clk), .rst(bc_rst),
    .cpu_memrq(c_cpu_memrq), .cpu_rnw(c_cpu_rnw), .cpu_addr(c_cpu_addr), .cpu_wdata(16'h0000),
    .cpu_rdata(c_cpu_rdata), .cpu_wait(c_cpu_wait),
    .host_halt(1'b0), .host_req(1'b0), .host_we(1'b0), .host_addr(12'h000),
    .host_wdata(16'h0000), .host_ack(c_host_ack), .host_rdata(c_host_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_rdata(c_mem_rdata)
  );

  // Synchronous memories: data appears on the edge after mem_en and holds.
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
      else          a_mem_rdata <= mem_a[a_mem_addr];
    end
    if (b_mem_en) begin
      if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      else          b_mem_rdata <= mem_b[b_mem_addr];
    end
    if (c_mem_en) begin
      if (c_mem_we) mem_c[c_mem_addr] <= c_mem_wdata;
      else          c_mem_rdata <= mem_c[c_mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [11:0] order [$];
    int          n_done, n_ack, n_cpu_issue, n_wait_low, n_en, lat;

    n_checks = 0;
    n_errors = 0;
    a_rst = 1'b1; bc_rst = 1'b1;
    a_cpu_memrq = 1'b0; a_cpu_rnw = 1'b1; a_cpu_addr = '0; a_cpu_wdata = '0;
    a_host_halt = 1'b0; a_host_req = 1'b0; a_host_we = 1'b0; a_host_addr = '0; a_host_wdata = '0;
    b_host_req = 1'b0; b_host_we = 1'b0; b_host_addr = '0; b_host_wdata = '0;
    c_cpu_memrq = 1'b0; c_cpu_rnw = 1'b1; c_cpu_addr = '0;
    a_mem_rdata = '0; b_mem_rdata = '0; c_mem_rdata = '0;
    mem_a[12'h005] = 16'h1234;
    mem_a[12'h010] = 16'h1111;
    mem_a[12'h020] = 16'h2222;
    mem_a[12'h030] = 16'h3333;
    mem_a[12'h040] = 16'h4444;
    mem_c[12'h007] = 16'h7777;
    mem_c[12'h008] = 16'h8888;

    repeat (3) @(negedge clk);
    a_rst = 1'b0; bc_rst = 1'b0;
    #1;
    check("rst_mem_en", a_mem_en, 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_cpu_rdata", a_cpu_rdata, 0);
    check("rst_host_rdata", a_host_rdata, 0);
    check("rst_host_ack", a_host_ack, 0);
    check("rst_cpu_wait", a_cpu_wait, 0);

    // CPU read, W=1
    @(negedge clk);
    a_cpu_rnw = 1'b1; a_cpu_addr = 12'h005; a_cpu_memrq = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      #1;
      check("cpu_rd_mem_en", a_mem_en, (c == 1));
      check("cpu_rd_wait", a_cpu_wait, (c <= 3));
      if (c == 1) check("cpu_rd_mem_addr", a_mem_addr, 12'h005);
      if (c == 4) begin
        check("cpu_rd_data", a_cpu_rdata, 16'h1234);
        a_cpu_memrq = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    // Simultaneous persistent requests straight after reset
    @(negedge clk); a_rst = 1'b1;
    @(negedge clk); a_rst = 1'b0;
    a_cpu_addr = 12'h010; a_cpu_rnw = 1'b1; a_cpu_memrq = 1'b1;
    a_host_addr = 12'h020; a_host_we = 1'b0; a_host_req = 1'b1;
    n_done = 0; n_ack = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (a_mem_en) order.push_back(a_mem_addr);
      if (a_host_ack) n_ack++;
      if (a_cpu_memrq && !a_cpu_wait) n_done++;
      @(negedge clk);
    end
    check("tie_n_issue_min3", (order.size() >= 3), 1);
    if (order.size() >= 3) begin
      check("tie_order0", order[0], 12'h010);
      check("tie_order1", order[1], 12'h020);
      check("tie_order2", order[2], 12'h010);
    end
    check("tie_cpu_dones", n_done, 2);
    check("tie_host_acks", n_ack, 1);
    check("tie_cpu_rdata", a_cpu_rdata, 16'h1111);
    check("tie_host_rdata", a_host_rdata, 16'h2222);
    a_cpu_memrq = 1'b0; a_host_req = 1'b0;
    repeat (8) @(negedge clk);

    // Halt raised during a CPU fetch in WAIT
    a_cpu_addr = 12'h030; a_cpu_rnw = 1'b1; a_cpu_memrq = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c == 2) a_host_halt = 1'b1;
      if (c == 3) check("halt_fetch_wait", a_cpu_wait, 1);
      if (c == 4) begin
        check("halt_fetch_wait_rel", a_cpu_wait, 0);
        check("halt_fetch_data", a_cpu_rdata, 16'h3333);
        a_cpu_memrq = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    @(negedge clk);
    a_cpu_addr = 12'h040; a_cpu_memrq = 1'b1;
    a_host_addr = 12'h020; a_host_we = 1'b0; a_host_req = 1'b1;
    n_cpu_issue = 0; n_wait_low = 0; n_ack = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (a_mem_en && a_mem_addr == 12'h040) n_cpu_issue++;
      if (!a_cpu_wait) n_wait_low++;
      if (a_host_ack) begin
        n_ack++;
        a_host_req = 1'b0;
      end
      @(negedge clk);
    end
    check("halt_no_cpu_issue", n_cpu_issue, 0);
    check("halt_cpu_wait_held", n_wait_low, 0);
    check("halt_host_ack", n_ack, 1);
    a_host_halt = 1'b0;
    lat = 0;
    #1;
    while (a_cpu_wait && lat < 12) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("unhalt_latency", lat, 4);
    check("unhalt_cpu_rdata", a_cpu_rdata, 16'h4444);
    a_cpu_memrq = 1'b0;

    // Reset during WAIT of a host read
    @(negedge clk);
    @(negedge clk);
    a_host_addr = 12'h020; a_host_we = 1'b0; a_host_req = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_issue", a_mem_en, 1);
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_mem_en", a_mem_en, 0);
    check("rstmid_host_rdata", a_host_rdata, 0);
    a_rst = 1'b0; a_host_req = 1'b0;
    n_ack = 0; n_en = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (a_host_ack) n_ack++;
      if (a_mem_en) n_en++;
    end
    check("rstmid_no_ack", n_ack, 0);
    check("rstmid_no_mem_en", n_en, 0);
    check("rstmid_rdata_kept0", a_host_rdata, 0);

    // Host write then read, W=0
    @(negedge clk);
    b_host_addr = 12'h0A0; b_host_wdata = 16'hBEEF; b_host_we = 1'b1; b_host_req = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      #1;
      check("host_ack", b_host_ack, (c == 3) || (c == 7));
      check("host_mem_en", b_mem_en, (c == 1) || (c == 5));
      if (c == 1) check("host_wr_we", b_mem_we, 1);
      if (c == 5) check("host_rd_we", b_mem_we, 0);
      if (c == 3) begin
        check("host_wr_rdata_kept", b_host_rdata, 0);
        b_host_we = 1'b0;
      end
      if (c == 7) begin
        check("host_rd_data", b_host_rdata, 16'hBEEF);
        b_host_req = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    // W=7: two CPU reads
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      c_cpu_addr = 12'(7 + k); c_cpu_rnw = 1'b1; c_cpu_memrq = 1'b1;
      for (int c = 0; c <= 10; c++) begin
        #1;
        check("w7_mem_en", c_mem_en, (c == 1));
        check("w7_cpu_wait", c_cpu_wait, (c <= 9));
        if (c == 9) check("w7_rdata_before", c_cpu_rdata, (k == 0) ? 16'h0000 : 16'h7777);
        if (c == 10) begin
          check("w7_rdata", c_cpu_rdata, (k == 0) ? 16'h7777 : 16'h8888);
          c_cpu_memrq = 1'b0;
        end else begin
          @(negedge clk);
        end
      end
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
